// File: rtl/tx_byte_fifo_pkg.sv
// Shared host-link package.
// Holds the host-link opcode constants and the default sizing of the
// transmit byte FIFO that sits between the VRAM command engine response
// path and the host transmitter.
package tx_byte_fifo_pkg;

  // Default storage depth in bytes (power of two, 4..256).
  localparam int FIFO_DEPTH_DEFAULT = 16;
  // Default occupancy at or above which almost_full_o asserts.
  localparam int FIFO_AFULL_DEFAULT = 12;

  // Host-link command opcodes.
  typedef enum logic [7:0] {
    OP_NOP        = 8'h00,
    OP_VRAM_READ  = 8'h01,
    OP_VRAM_WRITE = 8'h02,
    OP_STATUS     = 8'h03
  } host_op_e;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tx_byte_fifo_byte_ram.sv
// byte_ram: storage array for tx_byte_fifo.
// One synchronous write port and one asynchronous read port, which is what
// gives the FIFO its first-word fall-through head byte. Contents are never
// reset.
// Ports:
//   clock  - system clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write byte
//   raddr  - read address
//   rdata  - byte at raddr (combinational)
module byte_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: byte FIFO from the VRAM command engine response path to
// the host transmitter. First-word fall-through, ready/valid on both sides,
// sticky overflow/underflow flags.
// Ports:
//   clock, reset       - clock, synchronous active-high reset
//   clear_i            - flush stored bytes (error flags kept)
//   in_data_i/valid_i  - write side;  in_ready_o = not full
//   out_data_o/valid_o - head byte;   out_ready_i = consumer takes it
//   level_o            - occupancy 0..DEPTH
//   almost_full_o      - level_o >= AFULL_LEVEL
//   error_overflow_o   - sticky: valid presented while full
//   error_underflow_o  - sticky: ready presented while empty
module tx_byte_fifo
  import tx_byte_fifo_pkg::*;
#(
  parameter int DEPTH       = FIFO_DEPTH_DEFAULT,
  parameter int AFULL_LEVEL = FIFO_AFULL_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear_i,
  input  logic [7:0]                    in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [7:0]                    out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [level_width(DEPTH)-1:0] level_o,
  output logic                          almost_full_o,
  output logic                          error_overflow_o,
  output logic                          error_underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          overflow_reg;
  logic          underflow_reg;

  logic push;
  logic pop;
  logic ram_we;

  // Handshake flags depend only on registered occupancy, never on the
  // opposite side's same-cycle handshake, so a full FIFO is not writable
  // even while it is being drained.
  assign in_ready_o  = (level_reg != LW'(DEPTH));
  assign out_valid_o = (level_reg != '0);

  assign push = in_valid_i  && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // A flush or reset in the same cycle discards the incoming byte.
  assign ram_we = push && !clear_i && !reset;

  byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_byte_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wr_ptr_reg),
    .wdata (in_data_i),
    .raddr (rd_ptr_reg),
    .rdata (out_data_o)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      // Flags look at the raw request, independent of clear_i.
      if (in_valid_i && !in_ready_o) begin
        overflow_reg <= 1'b1;
      end
      if (out_ready_i && !out_valid_o) begin
        underflow_reg <= 1'b1;
      end

      if (clear_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0.
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   level_reg <= level_reg + 1'b1;
          2'b01:   level_reg <= level_reg - 1'b1;
          default: level_reg <= level_reg;
        endcase
      end
    end
  end

  assign level_o           = level_reg;
  assign almost_full_o     = (level_reg >= LW'(AFULL_LEVEL));
  assign error_overflow_o  = overflow_reg;
  assign error_underflow_o = underflow_reg;

endmodule
